// File: rtl/i2s_rx_master.sv
// I2S master receiver: divides clk_in into SCK, generates WS, deserialises SD MSB-first
// and presents each completed slot sample through a one-entry valid/ready output register.
module i2s_rx_master #(
  parameter int         CLK_DIV      = 4,
  parameter int         DATA_W       = 24,
  parameter logic [1:0] CHANNEL_MASK = 2'b01
) (
  input  logic              clk_in,
  input  logic              resetn,
  input  logic              enable,
  output logic              sck,
  output logic              ws,
  input  logic              sd,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_right,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int               DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [4:0]       SLOT_LAST = 5'(DATA_W);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [5:0]        r_bit_cnt;
  logic              r_sck;
  logic [DATA_W-1:0] r_shift;
  logic              r_done;
  logic              r_done_right;
  logic [DATA_W-1:0] r_sample_data;
  logic              r_sample_right;
  logic              r_sample_valid;
  logic              r_overrun;

  logic [4:0] w_slot_bit;
  logic       w_rise;
  logic       w_fall;
  logic       w_capture;
  logic       w_complete;
  logic       w_load;
  logic       w_drop;

  assign w_slot_bit = r_bit_cnt[4:0];
  assign w_rise     = enable && (r_div_cnt == DIV_HALF);
  assign w_fall     = enable && (r_div_cnt == '0) && r_sck;
  // Slot bit 0 is the I2S one-bit delay; bits past DATA_W are high-Z from the mic.
  assign w_capture  = w_rise && (w_slot_bit != 5'd0) && (w_slot_bit <= SLOT_LAST);
  assign w_complete = w_rise && (w_slot_bit == SLOT_LAST) && CHANNEL_MASK[r_bit_cnt[5]];

  assign w_load = r_done && (!r_sample_valid || sample_ready);
  assign w_drop = r_done && r_sample_valid && !sample_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours; the reset term is inside the clocked branch
  // because reset here is synchronous.
  always_ff @(posedge clk_in) begin
    if (!resetn || !enable) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_shift   <= '0;
    end else begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
      r_sck     <= (r_div_cnt >= DIV_HALF);
      if (w_fall) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_capture) begin
        r_shift <= (r_shift << 1) | DATA_W'(sd);
      end
    end
  end

  // Completion is registered so the output loads one cycle after the LSB rise edge.
  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      r_done       <= 1'b0;
      r_done_right <= 1'b0;
    end else begin
      r_done       <= w_complete;
      r_done_right <= r_bit_cnt[5];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      r_sample_data  <= '0;
      r_sample_right <= 1'b0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      if (w_load) begin
        r_sample_data  <= r_shift;
        r_sample_right <= r_done_right;
        r_sample_valid <= 1'b1;
      end else if (r_sample_valid && sample_ready) begin
        r_sample_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign sck          = r_sck;
  assign ws           = r_bit_cnt[5];
  assign sample_data  = r_sample_data;
  assign sample_right = r_sample_right;
  assign sample_valid = r_sample_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_i2s_rx_master.sv
// Bench for i2s_rx_master: two instances (both slots / left only) share one mic model,
// checked against a timing model built from edge counts since enable.
module tb_i2s_rx_master;

  localparam int       CLK_DIV = 4;
  localparam int       DATA_W  = 24;
  localparam int       HALF    = CLK_DIV / 2;
  localparam int       FRAME   = 64 * CLK_DIV;
  localparam bit [3:0] MASKS   = 4'b0111;  // [1:0] instance 0 = 2'b11, [3:2] instance 1 = 2'b01

  logic clk_in = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic sd = 1'b0;
  logic sample_ready = 1'b0;
  logic overrun_clr = 1'b0;
  logic [1:0]        sck, ws, s_right, s_valid, ovr;
  logic [DATA_W-1:0] s_data [2];

  i2s_rx_master #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .CHANNEL_MASK(2'b11)) dut_lr (
    .clk_in(clk_in), .resetn(resetn), .enable(enable), .sck(sck[0]), .ws(ws[0]), .sd(sd),
    .sample_data(s_data[0]), .sample_right(s_right[0]), .sample_valid(s_valid[0]),
    .sample_ready(sample_ready), .overrun(ovr[0]), .overrun_clr(overrun_clr));

  i2s_rx_master #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .CHANNEL_MASK(2'b01)) dut_l (
    .clk_in(clk_in), .resetn(resetn), .enable(enable), .sck(sck[1]), .ws(ws[1]), .sd(sd),
    .sample_data(s_data[1]), .sample_right(s_right[1]), .sample_valid(s_valid[1]),
    .sample_ready(sample_ready), .overrun(ovr[1]), .overrun_clr(overrun_clr));

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: p = enabled edges since the interface last started.
  int                p = 0;
  logic [DATA_W-1:0] lw [16];
  logic [DATA_W-1:0] rw [16];
  bit                pend [2];
  logic [DATA_W-1:0] pend_data;
  bit                pend_right;
  bit                e_valid [2];
  bit                e_right [2];
  bit                e_ovr [2];
  logic [DATA_W-1:0] e_data [2];
  bit                e_sck = 1'b0;
  bit                e_ws = 1'b0;

  function automatic logic [DATA_W-1:0] word_of(int m);
    int frame;
    frame = (m / 64) % 16;
    return (((m / 32) % 2) == 1) ? rw[frame] : lw[frame];
  endfunction

  function automatic logic [DATA_W+4:0] obs(int d);
    return {sck[d], ws[d], s_valid[d], s_right[d], ovr[d], s_data[d]};
  endfunction

  function automatic logic [DATA_W+4:0] exp_of(int d);
    return {e_sck, e_ws, e_valid[d], e_right[d], e_ovr[d], e_data[d]};
  endfunction

  task automatic fill_words(input bit rnd);
    for (int i = 0; i < 16; i++) begin
      lw[i] = rnd ? DATA_W'($urandom) : 24'h800001;
      rw[i] = rnd ? DATA_W'($urandom) : 24'h7FFFFE;
    end
  endtask

  task automatic model_step();
    int  m;
    int  slot;
    bit  comp;
    bit  drop;
    if (!resetn) begin
      p = 0; e_sck = 1'b0; e_ws = 1'b0;
      for (int d = 0; d < 2; d++) begin
        pend[d] = 1'b0; e_valid[d] = 1'b0; e_right[d] = 1'b0; e_ovr[d] = 1'b0; e_data[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        drop = 1'b0;
        if (pend[d]) begin
          if (!e_valid[d] || sample_ready) begin
            e_valid[d] = 1'b1; e_data[d] = pend_data; e_right[d] = pend_right;
          end else begin
            drop = 1'b1;
          end
        end else if (sample_ready) begin
          e_valid[d] = 1'b0;
        end
        if (drop) e_ovr[d] = 1'b1;
        else if (overrun_clr) e_ovr[d] = 1'b0;
      end
      if (enable) begin
        m    = p / CLK_DIV;
        slot = (m / 32) % 2;
        comp = ((p % CLK_DIV) == HALF) && ((m % 32) == DATA_W);
        for (int d = 0; d < 2; d++) pend[d] = comp && MASKS[2*d+slot];
        pend_data  = word_of(m);
        pend_right = (slot == 1);
        e_sck      = ((p % CLK_DIV) >= HALF);
        e_ws       = (slot == 1);
        p++;
      end else begin
        pend[0] = 1'b0; pend[1] = 1'b0; e_sck = 1'b0; e_ws = 1'b0; p = 0;
      end
    end
  endtask

  // Mic drives the bit for the upcoming edge; undriven slot positions get random junk.
  task automatic tick();
    logic [DATA_W-1:0] w;
    int                b;
    if (enable) begin
      w  = word_of(p / CLK_DIV);
      b  = (p / CLK_DIV) % 32;
      sd = (b >= 1 && b <= DATA_W) ? w[DATA_W-b] : 1'($urandom);
    end else begin
      sd = 1'($urandom);
    end
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; sample_ready = 1'b0; overrun_clr = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs(d) !== '0) begin
        miscompares++;
        $display("FAIL reset dut%0d {sck,ws,valid,right,ovr,data} got %h expected 0", d, obs(d));
      end
    end
    tick();
  endtask

  task automatic test_clock();
    int last_rise;
    bit prev_ws;
    bit prev_sck;
    last_rise = -1;
    fill_words(1'b1);
    sample_ready = 1'b1; enable = 1'b1; resetn = 1'b1;
    for (int c = 0; c < 2 * FRAME + 4; c++) begin
      prev_ws = ws[0]; prev_sck = sck[0];
      tick();
      vectors++;
      if ({sck[0], ws[0]} !== {e_sck, e_ws}) begin
        miscompares++;
        $display("FAIL clock c=%0d {sck,ws} got %b%b expected %b%b", c, sck[0], ws[0], e_sck, e_ws);
      end
      if (ws[0] !== prev_ws) begin
        vectors++;
        if (!(prev_sck === 1'b1 && sck[0] === 1'b0)) begin
          miscompares++;
          $display("FAIL ws_edge c=%0d sck went %b->%b expected 1->0", c, prev_sck, sck[0]);
        end
        if (ws[0] === 1'b1) begin
          if (last_rise >= 0) begin
            vectors++;
            if (c - last_rise != FRAME) begin
              miscompares++;
              $display("FAIL ws_period got %0d expected %0d", c - last_rise, FRAME);
            end
          end
          last_rise = c;
        end
      end
    end
  endtask

  task automatic test_stream_lr();
    logic [DATA_W:0] got [$];
    logic [DATA_W:0] want [4];
    int              last_l;
    last_l = -1;
    fill_words(1'b0);
    want[0] = {1'b0, 24'h800001}; want[1] = {1'b1, 24'h7FFFFE};
    want[2] = {1'b0, 24'h800001}; want[3] = {1'b1, 24'h7FFFFE};
    sample_ready = 1'b1;
    restart();
    for (int c = 0; c < 2 * FRAME + 8; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_of(d)) begin
          miscompares++;
          $display("FAIL stream dut%0d c=%0d got %h expected %h", d, c, obs(d), exp_of(d));
        end
      end
      if (s_valid[0] === 1'b1) got.push_back({s_right[0], s_data[0]});
      if (s_valid[1] === 1'b1) begin
        vectors++;
        if (s_right[1] !== 1'b0 || (last_l >= 0 && c - last_l != FRAME)) begin
          miscompares++;
          $display("FAIL left_only c=%0d right=%b gap=%0d expected right=0 gap=%0d",
                   c, s_right[1], c - last_l, FRAME);
        end
        last_l = c;
      end
    end
    vectors++;
    if (got.size() != 4) begin
      miscompares++;
      $display("FAIL stream_count got %0d expected 4", got.size());
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL stream_seq[%0d] got %h expected %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_random();
    fill_words(1'b1);
    restart();
    for (int c = 0; c < 4 * FRAME; c++) begin
      if ($urandom_range(0, 49) == 0) sample_ready = ~sample_ready;
      overrun_clr = ($urandom_range(0, 39) == 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_of(d)) begin
          miscompares++;
          $display("FAIL random dut%0d c=%0d got %h expected %h", d, c, obs(d), exp_of(d));
        end
      end
    end
    overrun_clr = 1'b0;
  endtask

  task automatic test_overrun();
    int c;
    fill_words(1'b1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    enable = 1'b1; sample_ready = 1'b0; overrun_clr = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_of(d)) begin
          miscompares++;
          $display("FAIL overrun_run dut%0d i=%0d got %h expected %h", d, i, obs(d), exp_of(d));
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({s_valid[d], s_right[d], ovr[d], s_data[d]} !== {3'b101, lw[0]}) begin
        miscompares++;
        $display("FAIL overrun_hold dut%0d {valid,right,ovr,data} got %h expected %h",
                 d, {s_valid[d], s_right[d], ovr[d], s_data[d]}, {3'b101, lw[0]});
      end
    end
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    vectors++;
    if (ovr !== 2'b00) begin
      miscompares++;
      $display("FAIL overrun_clr got %b expected 00", ovr);
    end
    c = 0;
    while (ovr[0] !== 1'b1 && c < FRAME) begin
      tick();
      c++;
    end
    vectors++;
    if (ovr[0] !== 1'b1 || s_data[0] !== lw[0]) begin
      miscompares++;
      $display("FAIL overrun_redrop ovr=%b data=%h expected ovr=1 data=%h", ovr[0], s_data[0], lw[0]);
    end
  endtask

  task automatic test_back_to_back();
    fill_words(1'b1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    enable = 1'b1; sample_ready = 1'b0; overrun_clr = 1'b0;
    for (int c = 0; c < 2 * FRAME + 8; c++) begin
      sample_ready = pend[0];
      tick();
      vectors++;
      if (obs(0) !== exp_of(0)) begin
        miscompares++;
        $display("FAIL b2b c=%0d got %h expected %h", c, obs(0), exp_of(0));
      end
      if (sample_ready) begin
        vectors++;
        if ({s_valid[0], ovr[0]} !== 2'b10) begin
          miscompares++;
          $display("FAIL b2b_load c=%0d {valid,ovr} got %b%b expected 10", c, s_valid[0], ovr[0]);
        end
      end
    end
    sample_ready = 1'b0;
  endtask

  task automatic test_disable();
    bit seen;
    seen = 1'b0;
    fill_words(1'b1);
    sample_ready = 1'b1;
    restart();
    repeat (10 * CLK_DIV + 2) tick();
    enable = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      vectors++;
      if ({sck[0], ws[0], s_valid[0], sck[1], ws[1], s_valid[1]} !== 6'b0) begin
        miscompares++;
        $display("FAIL disabled c=%0d {sck,ws,valid}x2 got %b expected 000000",
                 c, {sck[0], ws[0], s_valid[0], sck[1], ws[1], s_valid[1]});
      end
    end
    enable = 1'b1;
    for (int c = 0; c < FRAME + 8; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_of(d)) begin
          miscompares++;
          $display("FAIL reenable dut%0d c=%0d got %h expected %h", d, c, obs(d), exp_of(d));
        end
      end
      if (s_valid[0] === 1'b1 && !seen) begin
        seen = 1'b1;
        vectors++;
        if ({s_right[0], s_data[0]} !== {1'b0, lw[0]}) begin
          miscompares++;
          $display("FAIL resume_left got %h expected %h", {s_right[0], s_data[0]}, {1'b0, lw[0]});
        end
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL resume_timeout no sample within %0d cycles", FRAME + 8);
    end
    repeat (37) tick();
    resetn = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs(d) !== '0) begin
        miscompares++;
        $display("FAIL midframe_reset dut%0d got %h expected 0", d, obs(d));
      end
    end
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clock();
    test_stream_lr();
    test_random();
    test_overrun();
    test_back_to_back();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
